seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_pkg.sv | 46 ++++
 rtl/seg7_hex_decode.sv | 27 ++
 rtl/seven_seg_scanner.sv | 139 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared segment encodings for the seven-segment scanner.
// Cathode bit order is {g,f,e,d,c,b,a}, all active-low.
package seven_seg_pkg;

  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_t;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0011000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

  localparam seg_t SEG_TABLE [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3,
    SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B,
    SEG_C, SEG_D, SEG_E, SEG_F
  };

  function automatic seg_t seg_lookup(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decode with blanking.
// SEVEN_SEG_HEX_EN selects A-F glyphs; otherwise 10-15 show a dash.
module seg7_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

`ifdef SEVEN_SEG_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  always_comb begin
    seg_o = seg_lookup(nib_i);
    if (!HEX_EN && (nib_i > 4'd9)) begin
      seg_o = SEG_DASH;
    end
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with frame-synchronous updates.
// Optional hex glyphs via SEVEN_SEG_HEX_EN (see seg7_hex_decode).
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [6:0]              cathode,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    update_pending,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_TC    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         dval_q, dval_d;
  logic [NUM_DIGITS-1:0] ddp_q, ddp_d;
  logic [NUM_DIGITS-1:0] dblk_q, dblk_d;
  logic [VW-1:0]         pval_q, pval_d;
  logic [NUM_DIGITS-1:0] pdp_q, pdp_d;
  logic [NUM_DIGITS-1:0] pblk_q, pblk_d;
  logic                  pend_q, pend_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            cath_q, cath_d;
  logic                  dp_q, dp_d;
  logic                  fdone_q;

  logic       slot_end;
  logic       wrap;
  logic [3:0] nib;
  logic       cur_blk;

  assign slot_end = (cnt_q == CNT_TC);
  assign wrap     = slot_end && (idx_q == IDX_LAST);
  assign nib      = dval_q[{idx_q, 2'b00} +: 4];
  assign cur_blk  = dblk_q[idx_q];

  seg7_hex_decode u_dec (
    .nib_i   (nib),
    .blank_i (cur_blk),
    .seg_o   (cath_d)
  );

  always_comb begin
    cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    dval_d  = dval_q;
    ddp_d   = ddp_q;
    dblk_d  = dblk_q;
    pval_d  = pval_q;
    pdp_d   = pdp_q;
    pblk_d  = pblk_q;
    pend_d  = pend_q;
    anode_d = '1;
    dp_d    = cur_blk | ~ddp_q[idx_q];

    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (cnt_q >= CNT_GUARD) begin
      anode_d[idx_q] = 1'b0;
    end

    // A load landing on the boundary bypasses the pending stage.
    if (load && wrap) begin
      dval_d = value;
      ddp_d  = dp_in;
      dblk_d = blank_in;
      pend_d = 1'b0;
    end else if (load) begin
      pval_d = value;
      pdp_d  = dp_in;
      pblk_d = blank_in;
      pend_d = 1'b1;
    end else if (wrap && pend_q) begin
      dval_d = pval_q;
      ddp_d  = pdp_q;
      dblk_d = pblk_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      dval_q  <= '0;
      ddp_q   <= '0;
      dblk_q  <= '0;
      pval_q  <= '0;
      pdp_q   <= '0;
      pblk_q  <= '0;
      pend_q  <= 1'b0;
      anode_q <= '1;
      cath_q  <= SEG_BLANK;
      dp_q    <= 1'b1;
      fdone_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dval_q  <= dval_d;
      ddp_q   <= ddp_d;
      dblk_q  <= dblk_d;
      pval_q  <= pval_d;
      pdp_q   <= pdp_d;
      pblk_q  <= pblk_d;
      pend_q  <= pend_d;
      anode_q <= anode_d;
      cath_q  <= cath_d;
      dp_q    <= dp_d;
      fdone_q <= wrap;
    end
  end

  assign cathode        = cath_q;
  assign dp             = dp_q;
  assign anode          = anode_q;
  assign update_pending = pend_q;
  assign frame_done     = fdone_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner against a cycle-count model.
// Honours SEVEN_SEG_HEX_EN for the expected glyphs of nibbles 10-15.
module tb_seven_seg_scanner;

  localparam int N  = 4;
  localparam int R  = 8;
  localparam int G  = 2;
  localparam int RN = N * R;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic [6:0]  cathode;
  logic        dp;
  logic [3:0]  anode;
  logic        update_pending;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .GUARD_CYCLES (G)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .value          (value),
    .dp_in          (dp_in),
    .blank_in       (blank_in),
    .load           (load),
    .cathode        (cathode),
    .dp             (dp),
    .anode          (anode),
    .update_pending (update_pending),
    .frame_done     (frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: k = clock edges since reset release; shown/pending frames.
  int          k;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, m_blk, p_dp, p_blk;
  bit          m_pend;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
`ifdef SEVEN_SEG_HEX_EN
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      15: return 7'b0001110;
`endif
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic cycle(input logic ld, input logic [15:0] v,
                       input logic [3:0] d, input logic [3:0] b);
    int         pc, pi;
    logic [3:0] ea;
    logic [6:0] ec;
    logic       ed;
    bit         bnd;
    load     = ld;
    value    = v;
    dp_in    = d;
    blank_in = b;
    pc  = k % R;
    pi  = (k / R) % N;
    ea  = (pc < G) ? 4'hF : ~(4'b0001 << pi);
    ec  = m_blk[pi] ? 7'h7F : ref_seg(int'(m_val[pi*4 +: 4]));
    ed  = m_blk[pi] | ~m_dp[pi];
    bnd = (k % RN) == RN - 1;
    if (ld && bnd) begin
      m_val = v; m_dp = d; m_blk = b; m_pend = 0;
    end else if (ld) begin
      p_val = v; p_dp = d; p_blk = b; m_pend = 1;
    end else if (bnd && m_pend) begin
      m_val = p_val; m_dp = p_dp; m_blk = p_blk; m_pend = 0;
    end
    @(posedge clk);
    #1;
    chk("anode", 32'(anode), 32'(ea));
    chk("cathode", 32'(cathode), 32'(ec));
    chk("dp", 32'(dp), 32'(ed));
    chk("update_pending", 32'(update_pending), 32'(m_pend));
    chk("frame_done", 32'(frame_done), 32'(bnd));
    k++;
    load = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_cathode", 32'(cathode), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_pending", 32'(update_pending), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    m_val = '0; m_dp = '0; m_blk = '0;
    p_val = '0; p_dp = '0; p_blk = '0;
    m_pend = 0;
  endtask

  initial begin
    logic ld;
    do_reset();
    repeat (70) cycle(1'b0, 16'h0, 4'h0, 4'h0);

    while ((k % RN) != 10) cycle(1'b0, 16'h0, 4'h0, 4'h0);
    cycle(1'b1, 16'h4321, 4'h0, 4'h0);
    repeat (60) cycle(1'b0, 16'h0, 4'h0, 4'h0);

    while ((k % RN) != RN - 1) cycle(1'b0, 16'h0, 4'h0, 4'h0);
    cycle(1'b1, 16'h9999, 4'h0, 4'h0);
    repeat (40) cycle(1'b0, 16'h0, 4'h0, 4'h0);

    cycle(1'b1, 16'h00FA, 4'b0001, 4'b0100);
    repeat (70) cycle(1'b0, 16'h0, 4'h0, 4'h0);

    repeat (1500) begin
      ld = ($urandom_range(0, 11) == 0) ||
           (((k % RN) == RN - 1) && ($urandom_range(0, 2) == 0));
      cycle(ld, 16'($urandom), 4'($urandom),
            4'($urandom) & 4'($urandom));
    end

    while (((k / R) % N) != 2 || (k % R) != 1)
      cycle(1'b0, 16'h0, 4'h0, 4'h0);
    cycle(1'b1, 16'h5678, 4'hF, 4'h0);
    cycle(1'b0, 16'h0, 4'h0, 4'h0);
    do_reset();
    repeat (70) cycle(1'b0, 16'h0, 4'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
